mmio_axi_master: RTL and testbench

Bridges the core's single-outstanding load/store request port to an AXI4-Lite master interface. It feeds memory-mapped peripherals such as the timer (mtime/mtimecmp) block. The core issues an enable pulse and waits for a done pulse carrying read data and a fault flag. A per-transaction timeout ensures a silent slave cannot hang the core.

---
 rtl/mmio_axi_master.sv | 169 ++++++++++++++++
 tb/tb_mmio_axi_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_axi_master.sv
// ============================================================================
// Module   : mmio_axi_master
// Purpose  : Single-outstanding core load/store port to AXI4-Lite master,
//            with per-transaction timeout abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_axi_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    output logic [2:0]  m_axi_arprot,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [2:0]  m_axi_awprot,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    localparam logic [31:0] c_timeout    = 32'(TIMEOUT_CYCLES);
    localparam bit          c_timeout_en = (TIMEOUT_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic [31:0] r_cnt;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_done;
    logic        r_fault;
    logic        w_accept;
    logic        w_complete;
    logic        w_timeout;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_unused_resp;

    assign w_unused_resp = ^{m_axi_rresp[0], m_axi_bresp[0]};

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        w_accept     = (r_state == S_IDLE) && enable;
        w_aw_hs      = (r_state == S_W) && !r_aw_done && m_axi_awready;
        w_w_hs       = (r_state == S_W) && !r_w_done && m_axi_wready;
        case (r_state)
            S_IDLE: if (enable) w_state_next = write ? S_W : S_AR;
            S_AR:   if (m_axi_arready) w_state_next = S_R;
            S_R: begin
                if (m_axi_rvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            // AW and W may complete in either order or together.
            S_W: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_state_next = S_B;
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    w_complete   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        // A response landing in the expiry cycle still wins as a normal completion.
        if (c_timeout_en && (r_state != S_IDLE) && !w_complete &&
            ((r_cnt + 32'd1) >= c_timeout)) begin
            w_timeout    = 1'b1;
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_rdata   <= 32'd0;
            r_cnt     <= 32'd0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_done    <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_complete || w_timeout;
            if (w_accept) begin
                r_addr    <= addr;
                r_wdata   <= wdata;
                r_wstrb   <= wstrb;
                r_cnt     <= 32'd0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_complete) begin
                if (r_state == S_R) begin
                    r_rdata <= m_axi_rdata;
                    r_fault <= m_axi_rresp[1];
                end else begin
                    r_fault <= m_axi_bresp[1];
                end
            end
            if (w_timeout) r_fault <= 1'b1;
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign fault         = r_fault;
    assign rdata         = r_rdata;
    assign m_axi_araddr  = r_addr;
    assign m_axi_arvalid = (r_state == S_AR);
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (r_state == S_R);
    assign m_axi_awaddr  = r_addr;
    assign m_axi_awvalid = (r_state == S_W) && !r_aw_done;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wvalid  = (r_state == S_W) && !r_w_done;
    assign m_axi_bready  = (r_state == S_B);

endmodule

`default_nettype wire

// File: tb/tb_mmio_axi_master.sv
// ============================================================================
// Module   : tb_mmio_axi_master
// Purpose  : Directed self-checking bench for mmio_axi_master (timeout = 16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_axi_master;

    logic        clk = 1'b0;
    logic        rst, enable, write;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
    logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic [2:0]  m_axi_arprot, m_axi_awprot;
    logic [1:0]  m_axi_rresp, m_axi_bresp;
    logic [3:0]  m_axi_wstrb;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mtime      = 32'd0;
    logic [31:0] mtimecmp   = 32'hFFFF_FFFF;
    logic [31:0] last_rdata = 32'd0;
    logic        timer_irq;

    always #5 clk = ~clk;

    // Timer slave model: free-running mtime, interrupt when mtime >= mtimecmp.
    always @(posedge clk) mtime <= rst ? 32'd0 : mtime + 32'd1;
    assign timer_irq = (mtime >= mtimecmp);

    mmio_axi_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .write(write), .addr(addr),
        .wdata(wdata), .wstrb(wstrb), .busy(busy), .done(done), .fault(fault),
        .rdata(rdata),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_arprot(m_axi_arprot),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_awprot(m_axi_awprot),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Zero-wait read: enable at cycle 0, done at cycle 3.
    task automatic do_read(input logic [31:0] a, input logic [31:0] d_in,
                           input logic [1:0] resp, input bit use_mtime);
        logic [31:0] d;
        enable = 1'b1; write = 1'b0; addr = a; m_axi_arready = 1'b1;
        step();
        enable = 1'b0;
        chk("rd_busy", busy, 1);
        chk("rd_arvalid", m_axi_arvalid, 1);
        chk("rd_araddr", m_axi_araddr, a);
        chk("rd_rready_early", m_axi_rready, 0);
        step();
        chk("rd_arvalid_drop", m_axi_arvalid, 0);
        chk("rd_rready", m_axi_rready, 1);
        chk("rd_done_early", done, 0);
        d = use_mtime ? mtime : d_in;
        m_axi_rvalid = 1'b1; m_axi_rdata = d; m_axi_rresp = resp;
        step();
        m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rresp = 2'b00;
        chk("rd_done", done, 1);
        chk("rd_busy_clr", busy, 0);
        chk("rd_rdata", rdata, d);
        chk("rd_fault", fault, resp[1]);
        last_rdata = d;
        step();
        chk("rd_done_pulse", done, 0);
        chk("rd_rready_clr", m_axi_rready, 0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] resp);
        enable = 1'b1; write = 1'b1; addr = a; wdata = d; wstrb = s;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        step();
        enable = 1'b0;
        chk("wr_busy", busy, 1);
        chk("wr_awvalid", m_axi_awvalid, 1);
        chk("wr_wvalid", m_axi_wvalid, 1);
        chk("wr_awaddr", m_axi_awaddr, a);
        chk("wr_wdata", m_axi_wdata, d);
        chk("wr_wstrb", m_axi_wstrb, s);
        chk("wr_arvalid", m_axi_arvalid, 0);
        if (a == 32'h4000) mtimecmp = m_axi_wdata;
        step();
        chk("wr_valids_drop", {m_axi_awvalid, m_axi_wvalid}, 0);
        chk("wr_bready", m_axi_bready, 1);
        chk("wr_done_early", done, 0);
        m_axi_bvalid = 1'b1; m_axi_bresp = resp;
        step();
        m_axi_bvalid = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bresp = 2'b00;
        chk("wr_done", done, 1);
        chk("wr_fault", fault, resp[1]);
        chk("wr_rdata_kept", rdata, last_rdata);
        chk("wr_busy_clr", busy, 0);
        step();
        chk("wr_done_pulse", done, 0);
        chk("wr_bready_clr", m_axi_bready, 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; write = 1'b0; addr = 32'd0; wdata = 32'd0; wstrb = 4'd0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'd0; m_axi_rresp = 2'b00;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        step();
        step();
        chk("rst_ctrl", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
                         m_axi_bready, busy, done, fault}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_araddr", m_axi_araddr, 0);
        chk("rst_awaddr", m_axi_awaddr, 0);
        chk("rst_wdata", m_axi_wdata, 0);
        chk("rst_wstrb", m_axi_wstrb, 0);
        chk("rst_prot", {m_axi_arprot, m_axi_awprot}, 0);
        rst = 1'b0;
        step();

        // mtime low word read
        do_read(32'h0000_bff8, 32'd0, 2'b00, 1'b1);

        // mtimecmp write then read back
        do_write(32'h0000_4000, 32'h1234_5678, 4'hF, 2'b00);
        do_read(32'h0000_4000, 32'h1234_5678, 2'b00, 1'b0);
        chk("timer_irq_low", timer_irq, 0);

        // unmapped read faults; fault holds, then clears on a good access
        do_read(32'h0000_5000, 32'hDEAD_BEEF, 2'b10, 1'b0);
        chk("fault_hold", fault, 1);
        do_read(32'h0000_4000, 32'h1234_5678, 2'b00, 1'b0);
        chk("fault_cleared", fault, 0);

        // write with wready low for three cycles
        enable = 1'b1; write = 1'b1; addr = 32'h4004; wdata = 32'hCAFE_F00D; wstrb = 4'h3;
        m_axi_awready = 1'b1; m_axi_wready = 1'b0;
        step();
        enable = 1'b0;
        chk("sw_c1_valids", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
        step();
        for (int k = 2; k <= 3; k++) begin
            chk("sw_awvalid_low", m_axi_awvalid, 0);
            chk("sw_wvalid_high", m_axi_wvalid, 1);
            chk("sw_bready_low", m_axi_bready, 0);
            chk("sw_no_done", done, 0);
            step();
        end
        chk("sw_c4_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
        m_axi_wready = 1'b1;
        step();
        m_axi_wready = 1'b0; m_axi_awready = 1'b0;
        chk("sw_c5_wvalid", m_axi_wvalid, 0);
        chk("sw_c5_bready", m_axi_bready, 1);
        chk("sw_c5_done", done, 0);
        m_axi_bvalid = 1'b1; m_axi_bresp = 2'b00;
        step();
        m_axi_bvalid = 1'b0;
        chk("sw_done", done, 1);
        chk("sw_fault", fault, 0);
        step();
        chk("sw_single_done", done, 0);
        chk("sw_idle", busy, 0);

        // back-to-back reads: enable in the done cycle is accepted
        enable = 1'b1; write = 1'b0; addr = 32'h100; m_axi_arready = 1'b1;
        step();
        enable = 1'b0;
        step();
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1111_0000;
        step();
        m_axi_rvalid = 1'b0;
        chk("b2b_done1", done, 1);
        chk("b2b_rdata1", rdata, 32'h1111_0000);
        enable = 1'b1; addr = 32'h104;
        step();
        enable = 1'b0;
        chk("b2b_done1_pulse", done, 0);
        chk("b2b_busy2", busy, 1);
        chk("b2b_arvalid2", m_axi_arvalid, 1);
        chk("b2b_araddr2", m_axi_araddr, 32'h104);
        step();
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h2222_0000;
        step();
        m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
        chk("b2b_done2", done, 1);
        chk("b2b_rdata2", rdata, 32'h2222_0000);
        last_rdata = 32'h2222_0000;
        step();

        // timeout: arready never asserted; enables during busy are ignored
        enable = 1'b1; write = 1'b0; addr = 32'h6000; m_axi_arready = 1'b0;
        step();
        for (int k = 1; k <= 16; k++) begin
            chk("to_arvalid", m_axi_arvalid, 1);
            chk("to_busy", busy, 1);
            chk("to_no_done", done, 0);
            chk("to_no_aw", m_axi_awvalid, 0);
            enable = (k % 2 == 1); write = 1'b1; addr = 32'h7000;
            step();
        end
        enable = 1'b0; write = 1'b0;
        chk("to_done", done, 1);
        chk("to_fault", fault, 1);
        chk("to_arvalid_drop", m_axi_arvalid, 0);
        chk("to_busy_clr", busy, 0);
        chk("to_rdata_kept", rdata, last_rdata);
        step();
        chk("to_done_pulse", done, 0);
        chk("to_no_second_txn", {busy, m_axi_awvalid, m_axi_arvalid}, 0);
        do_read(32'h0000_0300, 32'h0BAD_F00D, 2'b00, 1'b0);

        // reset while in R aborts with no done
        enable = 1'b1; write = 1'b0; addr = 32'h200; m_axi_arready = 1'b1;
        step();
        enable = 1'b0;
        step();
        chk("rr_in_r", m_axi_rready, 1);
        m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5555_5555; m_axi_rresp = 2'b10; rst = 1'b1;
        step();
        rst = 1'b0; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rresp = 2'b00;
        chk("rr_ctrl", {m_axi_arvalid, m_axi_rready, busy, done, fault}, 0);
        chk("rr_rdata", rdata, 0);
        chk("rr_araddr", m_axi_araddr, 0);
        last_rdata = 32'd0;
        step();
        chk("rr_no_done", done, 0);
        do_read(32'h0000_0204, 32'hABCD_0123, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
